// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the tone path. The tone-to-period lookup and the
// square-wave oscillator both take their period width from here, so the two
// blocks always agree on the width of the period bus between them.
//
// Contents:
//   PERIOD_W    default width of a tone period (in clk cycles)
//   MIN_PERIOD  smallest period the oscillator will run; below this a cycle
//               cannot hold both a high and a low phase
//   osc_state_t oscillator FSM state
// ---------------------------------------------------------------------------
package synth_pkg;

   localparam int PERIOD_W   = 32;
   localparam int MIN_PERIOD = 2;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } osc_state_t;

endpackage : synth_pkg

// File: rtl/square_osc.sv
// ---------------------------------------------------------------------------
// square_osc
// Square-wave tone oscillator. Takes a tone period in clk cycles from the
// tone-to-period lookup plus a note gate and produces a 1-bit square wave.
// Each waveform cycle is floor(P/2) clks high followed by P-floor(P/2) clks
// low. Period and gate are only looked at when a cycle starts (the start
// edge out of IDLE and every boundary edge), so a pitch change or note-off
// always lets the running cycle finish intact.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   period       requested tone period in clks (clamped up to MIN_PERIOD)
//   gate         note held (1) / released (0), level-sensitive
//   audio_out    registered square-wave output
//   cycle_start  one-clk pulse on the edge a new waveform cycle begins
//   busy         high while the oscillator is running
// ---------------------------------------------------------------------------
module square_osc #(
   parameter int PERIOD_W   = synth_pkg::PERIOD_W,
   parameter int MIN_PERIOD = synth_pkg::MIN_PERIOD
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PERIOD_W-1:0] period,
   input  logic                gate,
   output logic                audio_out,
   output logic                cycle_start,
   output logic                busy
);

   import synth_pkg::*;

   localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);

   osc_state_t          state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [PERIOD_W-1:0] ap_q, ap_d;       // period of the cycle in progress
   logic                audio_d, cs_d, busy_d;

   logic [PERIOD_W-1:0] eff_period;
   logic [PERIOD_W-1:0] half;
   logic                at_boundary;
   logic                at_fall;

   // Clamp tiny requests so every cycle has at least one high and one low clk.
   assign eff_period = (period < MIN_P) ? MIN_P : period;

   // ap_q is never below MIN_PERIOD while in RUN, so half >= 1 and the
   // minus-one compares below cannot underflow there.
   assign half        = ap_q >> 1;
   assign at_boundary = (cnt_q == ap_q - ONE);
   assign at_fall     = (cnt_q == half - ONE);

   // -------------------------------------------------------------------------
   // Next-state / output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ap_d    = ap_q;
      audio_d = audio_out;
      cs_d    = 1'b0;
      busy_d  = busy;

      unique case (state_q)
         IDLE: begin
            audio_d = 1'b0;
            busy_d  = 1'b0;
            if (gate) begin
               ap_d    = eff_period;
               cnt_d   = '0;
               audio_d = 1'b1;
               cs_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end

         RUN: begin
            if (at_boundary) begin
               // Only place in RUN where gate and period are consulted.
               if (gate) begin
                  ap_d    = eff_period;
                  cnt_d   = '0;
                  audio_d = 1'b1;
                  cs_d    = 1'b1;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  audio_d = 1'b0;
                  busy_d  = 1'b0;
               end
            end else if (at_fall) begin
               audio_d = 1'b0;
               cnt_d   = cnt_q + ONE;
            end else begin
               cnt_d   = cnt_q + ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            audio_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register; reset aborts any cycle in progress immediately.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ap_q        <= '0;
         audio_out   <= 1'b0;
         cycle_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ap_q        <= ap_d;
         audio_out   <= audio_d;
         cycle_start <= cs_d;
         busy        <= busy_d;
      end
   end

endmodule : square_osc

// File: tb/tb_square_osc.sv
module tb_square_osc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] period;
  logic        gate;
  logic        audio_out;
  logic        cycle_start;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  logic [2:0] wave_q[$];

  square_osc dut (
    .clk         (clk),
    .rst         (rst),
    .period      (period),
    .gate        (gate),
    .audio_out   (audio_out),
    .cycle_start (cycle_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    int unsigned p;
    if (rst) begin
      wave_q.delete();
      exp_q.push_back(3'b000);
    end else begin
      if (wave_q.size() == 0 && gate) begin
        p = (period < 2) ? 2 : period;
        for (int k = 0; k < int'(p); k++)
          wave_q.push_back({(k < int'(p / 2)) ? 1'b1 : 1'b0,
                            (k == 0) ? 1'b1 : 1'b0, 1'b1});
      end
      if (wave_q.size() != 0) exp_q.push_back(wave_q.pop_front());
      else                    exp_q.push_back(3'b000);
    end
  end

  always @(negedge clk) begin
    logic [2:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({audio_out, cycle_start, busy} !== e) begin
        errors++;
        $display("FAIL osc_out t=%0t got audio/cs/busy=%b expected %b",
                 $time, {audio_out, cycle_start, busy}, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rst(input string tag);
    checks++;
    if ({audio_out, cycle_start, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state %s t=%0t got audio/cs/busy=%b expected 000",
               tag, $time, {audio_out, cycle_start, busy});
    end
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout t=%0t stimulus did not complete", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1; gate = 1'b0; period = 32'd0;
    cyc(2);
    chk_rst("initial");
    rst = 1'b0;
    cyc(2);

    period = 32'd10; gate = 1'b1;
    cyc(35);

    period = 32'd7;
    cyc(145);

    period = 32'd0;
    cyc(12);
    period = 32'd1;
    cyc(12);

    rst = 1'b1; cyc(1); rst = 1'b0;
    period = 32'd10; gate = 1'b1;
    cyc(4);
    period = 32'd4;
    cyc(24);

    rst = 1'b1; cyc(1); rst = 1'b0;
    period = 32'd10;
    cyc(3);
    gate = 1'b0;
    cyc(15);
    gate = 1'b1;
    cyc(12);

    gate = 1'b0; cyc(1); gate = 1'b1;
    cyc(20);

    rst = 1'b1; cyc(1); rst = 1'b0;
    gate = 1'b1; period = 32'd10;
    cyc(7);
    rst = 1'b1; cyc(1);
    chk_rst("mid_run");
    rst = 1'b0;
    cyc(12);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0)   period = $urandom_range(0, 24);
      if ($urandom_range(0, 19) == 0)  gate = ~gate;
      rst = ($urandom_range(0, 99) == 0);
      cyc(1);
    end
    rst = 1'b0; gate = 1'b0;
    cyc(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_square_osc

// File: doc/square_osc.md
Name: square_osc

Overview:
Square-wave tone oscillator that sits directly downstream of the tone-to-period lookup. It consumes the 32-bit `period` in clock cycles and a note `gate`, and produces a 1-bit audio square wave. The period is latched only at cycle boundaries, and note-off completes the current cycle, so pitch changes and note-off never clip a waveform mid-cycle.

Parameters:
PERIOD_W, 32, width of period input and internal counter
MIN_PERIOD, 2, smallest legal period; smaller requests are clamped to this value

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
period  input  PERIOD_W  requested tone period in clk cycles, from tone-to-period lookup
gate  input  1  note held (1) / released (0); level-sensitive
audio_out  output  1  registered square-wave output
cycle_start  output  1  one-clk pulse on the edge a new waveform cycle begins
busy  output  1  high while oscillator is in RUN

Behaviour:
- Reset: if rst=1 at an edge, the next state is:
  - state=IDLE, cnt=0, active_period=0
  - audio_out=0, cycle_start=0, busy=0
  - Reset applies regardless of state, and mid-cycle reset aborts the waveform immediately.
- Clamp: eff_period = (period < MIN_PERIOD) ? MIN_PERIOD : period. All compares are unsigned at PERIOD_W.
- Cycle timing:
  - half = active_period >> 1 (floor).
  - High time = half cycles; low time = active_period − half cycles.
  - Example: P=7 gives 3 high, 4 low.
- FSM states: IDLE, RUN.
- IDLE:
  - audio_out=0, busy=0.
  - At an edge with gate=1: active_period<=eff_period, cnt<=0, audio_out<=1, cycle_start<=1, busy<=1, state<=RUN.
  - Latency is 1 clk from gate sampled high to audio_out=1.
- RUN, each edge:
  - cycle_start<=0 by default.
  - If cnt == active_period−1 (boundary):
    - gate=1: active_period<=eff_period, cnt<=0, audio_out<=1, cycle_start<=1.
    - gate=0: state<=IDLE, cnt<=0, audio_out<=0, busy<=0.
  - Else if cnt == half−1: audio_out<=0, cnt<=cnt+1.
  - Else: cnt<=cnt+1.
- Boundary-only sampling:
  - gate and period are sampled only at the IDLE start edge and at the boundary edge.
  - Mid-cycle period changes are ignored until the next boundary.
  - Gate glitches low-then-high within a cycle are invisible.
- Simultaneous events:
  - rst beats everything.
  - At a boundary with gate=1 and a new period, the new period takes effect for the cycle starting that edge.
- Counter never wraps: cnt < active_period ≤ 2^PERIOD_W−1 always holds.
- P=MIN_PERIOD=2: output toggles every clk; cycle_start every 2 clks.

Decomposition:
- Shared package synth_pkg holds:
  - PERIOD_W and MIN_PERIOD defaults
  - osc_state_t enum {IDLE, RUN}
- The tone-to-period lookup and this block both import PERIOD_W from the package.
- No sub-module: counter, clamp and FSM are a single small process pair. A separate sub-module would only add ports.

Test Plan:
- Basic tone: rst 2 clks, period=10, gate=1 held → audio_out high 5 clks, low 5, repeating; cycle_start every 10 clks; busy=1 from first edge.
- Odd period: period=7, gate=1 → 3 high / 4 low per cycle; cycle_start spacing exactly 7 over 20 cycles.
- Clamp: period=0, then period=1, gate=1 → both behave as P=2: audio_out alternates 1,0 each clk.
- Pitch change: P=10 running, period→4 at cnt=3 → current cycle completes as 10 (5/5), following cycles 2 high / 2 low; cycle_start spacing 10 then 4.
- Note-off: P=10, gate drops at cnt=2 → waveform completes the full 10-clk cycle; busy and audio_out are 0 after the cnt=9 edge; no further cycle_start; gate re-raise restarts with 1-clk latency.
- Reset mid-run: P=10, rst=1 at cnt=6 with gate=1 → next clk audio_out=0, busy=0, cycle_start=0; after rst deasserts with gate=1, a fresh cycle starts on the next edge (cycle_start=1).
